// File: rtl/gfx_line_stream.sv
// gfx_line_stream: Bresenham line rasteriser that emits one pixel per cycle on a
// valid/ready stream. Octant handling (step signs, major axis) is derived
// internally from the two signed endpoints.
// Build option: define GFX_LINE_SKIP_LAST_EN to drop the endpoint pixel, so that
// consecutive polyline segments do not plot their shared vertex twice.
module gfx_line_stream #(
   parameter int POINT_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [POINT_W-1:0] pixel0_x_i,
   input  logic [POINT_W-1:0] pixel0_y_i,
   input  logic [POINT_W-1:0] pixel1_x_i,
   input  logic [POINT_W-1:0] pixel1_y_i,
   input  logic               start_i,
   input  logic               abort_i,
   output logic               busy_o,
   output logic               pix_valid_o,
   input  logic               pix_ready_i,
   output logic [POINT_W-1:0] pix_x_o,
   output logic [POINT_W-1:0] pix_y_o,
   output logic               pix_last_o,
   output logic               done_o
);

   localparam int DW = POINT_W + 1;   // width of |delta|
   localparam int EW = POINT_W + 3;   // width of the signed error term
   localparam logic [POINT_W-1:0] ONE_P = {{(POINT_W-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0]      ONE_D = {{(DW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

   state_t                state_reg;
   logic [POINT_W-1:0]    x0_reg, y0_reg, x1_reg, y1_reg;
   logic [DW-1:0]         dmajor_reg, dminor_reg;
   // Steps left on the major axis; zero means the major coordinate sits on the
   // (possibly skipped-adjusted) major endpoint.
   logic [DW-1:0]         rem_reg;
   logic                  sx_neg_reg, sy_neg_reg, x_major_reg;
   logic signed [EW-1:0]  err_reg;
   logic                  done_reg;

   logic signed [DW-1:0]  diff_x, diff_y;
   logic [DW-1:0]         dx, dy, setup_dmajor, setup_dminor;
   logic                  setup_x_major;

   logic signed [EW-1:0]  e_sum, err_next;
   logic signed [EW:0]    e_twice;
   logic                  bump_minor, step_x, step_y;
   logic [POINT_W-1:0]    x_next, y_next;

   // Abort during the DONE cycle must hide the completion pulse.
   assign done_o = done_reg & ~abort_i;

   // Endpoint deltas, step directions and axis selection used in SETUP.
   always_comb begin
      diff_x = $signed({x1_reg[POINT_W-1], x1_reg}) - $signed({x0_reg[POINT_W-1], x0_reg});
      diff_y = $signed({y1_reg[POINT_W-1], y1_reg}) - $signed({y0_reg[POINT_W-1], y0_reg});
      dx = diff_x[DW-1] ? -diff_x : diff_x;
      dy = diff_y[DW-1] ? -diff_y : diff_y;
      setup_x_major = (dx >= dy);
      setup_dmajor  = setup_x_major ? dx : dy;
      setup_dminor  = setup_x_major ? dy : dx;
   end

   // Next point and error term for one Bresenham step; the doubled error is
   // compared one bit wider than the register so it cannot wrap.
   always_comb begin
      e_sum      = err_reg + $signed({2'b00, dminor_reg});
      e_twice    = {e_sum, 1'b0};
      bump_minor = (e_twice >= $signed({3'b000, dmajor_reg}));
      err_next   = bump_minor ? (e_sum - $signed({2'b00, dmajor_reg})) : e_sum;
      step_x     = x_major_reg | bump_minor;
      step_y     = ~x_major_reg | bump_minor;
      x_next     = pix_x_o;
      y_next     = pix_y_o;
      if (step_x) begin
         x_next = sx_neg_reg ? (pix_x_o - ONE_P) : (pix_x_o + ONE_P);
      end
      if (step_y) begin
         y_next = sy_neg_reg ? (pix_y_o - ONE_P) : (pix_y_o + ONE_P);
      end
   end

   // Control FSM with registered stream outputs; abort beats any transfer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         x0_reg      <= '0;
         y0_reg      <= '0;
         x1_reg      <= '0;
         y1_reg      <= '0;
         dmajor_reg  <= '0;
         dminor_reg  <= '0;
         rem_reg     <= '0;
         sx_neg_reg  <= 1'b0;
         sy_neg_reg  <= 1'b0;
         x_major_reg <= 1'b0;
         err_reg     <= '0;
         done_reg    <= 1'b0;
         busy_o      <= 1'b0;
         pix_valid_o <= 1'b0;
         pix_last_o  <= 1'b0;
         pix_x_o     <= '0;
         pix_y_o     <= '0;
      end else if (abort_i && (state_reg != IDLE)) begin
         state_reg   <= IDLE;
         busy_o      <= 1'b0;
         pix_valid_o <= 1'b0;
         pix_last_o  <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  x0_reg    <= pixel0_x_i;
                  y0_reg    <= pixel0_y_i;
                  x1_reg    <= pixel1_x_i;
                  y1_reg    <= pixel1_y_i;
                  busy_o    <= 1'b1;
                  state_reg <= SETUP;
               end
            end
            SETUP: begin
               pix_x_o     <= x0_reg;
               pix_y_o     <= y0_reg;
               dmajor_reg  <= setup_dmajor;
               dminor_reg  <= setup_dminor;
               x_major_reg <= setup_x_major;
               sx_neg_reg  <= diff_x[DW-1];
               sy_neg_reg  <= diff_y[DW-1];
               err_reg     <= '0;
`ifdef GFX_LINE_SKIP_LAST_EN
               if (setup_dmajor == '0) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg   <= RUN;
                  pix_valid_o <= 1'b1;
                  rem_reg     <= setup_dmajor - ONE_D;
                  pix_last_o  <= (setup_dmajor == ONE_D);
               end
`else
               state_reg   <= RUN;
               pix_valid_o <= 1'b1;
               rem_reg     <= setup_dmajor;
               pix_last_o  <= (setup_dmajor == '0);
`endif
            end
            RUN: begin
               if (pix_valid_o && pix_ready_i) begin
                  if (pix_last_o) begin
                     state_reg   <= DONE;
                     pix_valid_o <= 1'b0;
                     pix_last_o  <= 1'b0;
                     done_reg    <= 1'b1;
                  end else begin
                     pix_x_o    <= x_next;
                     pix_y_o    <= y_next;
                     err_reg    <= err_next;
                     rem_reg    <= rem_reg - ONE_D;
                     pix_last_o <= (rem_reg == ONE_D);
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_o    <= 1'b0;
               done_reg  <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gfx_line_stream.sv
// tb_gfx_line_stream: directed scoreboard bench for gfx_line_stream.
// Stimulus pushes hand-computed pixels into a queue; a negedge monitor pops and
// compares every accepted pixel, checks stall stability and done_o timing.
module tb_gfx_line_stream;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic               last;
   } pix_t;

   logic        clk_i;
   logic        rst_i;
   logic [15:0] pixel0_x_i, pixel0_y_i, pixel1_x_i, pixel1_y_i;
   logic        start_i, abort_i;
   logic        busy_o, pix_valid_o, pix_ready_i;
   logic [15:0] pix_x_o, pix_y_o;
   logic        pix_last_o, done_o;

   gfx_line_stream #(.POINT_W(16)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pixel0_x_i (pixel0_x_i),
      .pixel0_y_i (pixel0_y_i),
      .pixel1_x_i (pixel1_x_i),
      .pixel1_y_i (pixel1_y_i),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .busy_o     (busy_o),
      .pix_valid_o(pix_valid_o),
      .pix_ready_i(pix_ready_i),
      .pix_x_o    (pix_x_o),
      .pix_y_o    (pix_y_o),
      .pix_last_o (pix_last_o),
      .done_o     (done_o)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   pix_t exp_q[$];
   pix_t line_q[$];
   int   pix_count  = 0;
   int   done_count = 0;
   bit   done_pending = 1'b0;
   bit   lone_ok      = 1'b0;
   bit   stall_prev   = 1'b0;
   pix_t stall_val;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_pix(input string name, input pix_t act, input pix_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got (%0d,%0d,last=%0b), expected (%0d,%0d,last=%0b)",
                    name, act.x, act.y, act.last, exp.x, exp.y, exp.last);
   endtask

   // Monitor: compares accepted pixels, stall stability and done timing.
   always @(negedge clk_i) begin
      pix_t got;
      pix_t want;
      if (rst_i) begin
         stall_prev   = 1'b0;
         done_pending = 1'b0;
      end else begin
         got = '{pix_x_o, pix_y_o, pix_last_o};
         if (done_pending) check_bit("done_after_last", done_o, 1'b1);
         if (done_o) begin
            check_bit("done_has_cause", done_pending | lone_ok, 1'b1);
            done_count++;
            $display("done pulse %0d", done_count);
         end
         done_pending = 1'b0;
         if (stall_prev) begin
            check_bit("stall_valid_held", pix_valid_o, 1'b1);
            check_pix("stall_pixel_held", got, stall_val);
         end
         stall_prev = 1'b0;
         if (pix_valid_o && !abort_i) begin
            if (pix_ready_i) begin
               $display("pixel %0d: (%0d,%0d) last=%0b", pix_count, got.x, got.y, got.last);
               if (exp_q.size() == 0) begin
                  check_int("pixel_was_expected", exp_q.size(), 1);
               end else begin
                  want = exp_q.pop_front();
                  check_pix("pixel", got, want);
               end
               pix_count++;
               if (pix_last_o) done_pending = 1'b1;
            end else begin
               stall_prev = 1'b1;
               stall_val  = got;
            end
         end
      end
   end

   task automatic pt(input int x, input int y);
      pix_t p;
      p.x = 16'(x);
      p.y = 16'(y);
      p.last = 1'b0;
      line_q.push_back(p);
   endtask

   // Moves the full hand-computed line into the scoreboard, marking the last pixel.
   task automatic commit_line(output bit has_pix);
`ifdef GFX_LINE_SKIP_LAST_EN
      void'(line_q.pop_back());
`endif
      has_pix = (line_q.size() > 0);
      if (has_pix) line_q[line_q.size()-1].last = 1'b1;
      foreach (line_q[i]) exp_q.push_back(line_q[i]);
      line_q.delete();
   endtask

   task automatic start_line(input int x0, input int y0, input int x1, input int y1,
                             input bit has_pix);
      @(posedge clk_i); #1;
      pixel0_x_i = 16'(x0);
      pixel0_y_i = 16'(y0);
      pixel1_x_i = 16'(x1);
      pixel1_y_i = 16'(y1);
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check_bit("setup_no_valid", pix_valid_o, 1'b0);
      check_bit("setup_busy", busy_o, 1'b1);
      @(posedge clk_i); #1;
      if (has_pix) check_bit("first_valid_latency", pix_valid_o, 1'b1);
   endtask

   task automatic wait_idle(input bit toggle);
      int n;
      n = 0;
      while (busy_o && n < 300) begin
         @(posedge clk_i); #1;
         if (toggle) pix_ready_i = ~pix_ready_i;
         n++;
      end
      check_bit("line_finished_in_time", busy_o, 1'b0);
   endtask

   task automatic draw(input int x0, input int y0, input int x1, input int y1,
                       input bit toggle, input bit poke);
      bit has_pix;
      int d0;
      commit_line(has_pix);
      lone_ok = !has_pix;
      d0 = done_count;
      pix_ready_i = 1'b1;
      start_line(x0, y0, x1, y1, has_pix);
      if (poke) begin
         pixel0_x_i = 16'(9);
         pixel0_y_i = 16'(9);
         pixel1_x_i = 16'(0);
         pixel1_y_i = 16'(0);
         start_i = 1'b1;
         @(posedge clk_i); #1;
         start_i = 1'b0;
      end
      wait_idle(toggle);
      pix_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check_int("queue_drained", exp_q.size(), 0);
      check_int("done_pulses", done_count - d0, 1);
      check_bit("idle_after_line", busy_o, 1'b0);
      lone_ok = 1'b0;
   endtask

   initial begin
      int d0;
      int base;
      int n;
      rst_i = 1'b0;
      start_i = 1'b0;
      abort_i = 1'b0;
      pix_ready_i = 1'b1;
      pixel0_x_i = '0;
      pixel0_y_i = '0;
      pixel1_x_i = '0;
      pixel1_y_i = '0;
      #1 rst_i = 1'b1;
      #2;
      check_bit("rst_busy", busy_o, 1'b0);
      check_bit("rst_valid", pix_valid_o, 1'b0);
      check_bit("rst_last", pix_last_o, 1'b0);
      check_bit("rst_done", done_o, 1'b0);
      check_int("rst_x", {16'd0, pix_x_o}, 0);
      check_int("rst_y", {16'd0, pix_y_o}, 0);
      #20 rst_i = 1'b0;

      // Shallow x-major line.
      pt(0,0); pt(1,1); pt(2,1); pt(3,2); pt(4,2);
      draw(0, 0, 4, 2, 1'b0, 1'b0);

      // Steep line with both steps negative; a start while busy must be ignored.
      pt(3,5); pt(3,4); pt(2,3); pt(2,2); pt(1,1); pt(1,0);
      draw(3, 5, 1, 0, 1'b0, 1'b1);

      // Horizontal line under a toggling ready.
      for (int i = 0; i <= 7; i++) pt(i, 0);
      draw(0, 0, 7, 0, 1'b1, 1'b0);

      // Degenerate single-point line.
      pt(-2,-2);
      draw(-2, -2, -2, -2, 1'b0, 1'b0);

      // Abort after the third transfer of a diagonal.
      for (int i = 0; i < 3; i++) begin
         pix_t p;
         p.x = 16'(i);
         p.y = 16'(i);
         p.last = 1'b0;
         exp_q.push_back(p);
      end
      d0 = done_count;
      base = pix_count;
      pix_ready_i = 1'b1;
      start_line(0, 0, 10, 10, 1'b1);
      n = 0;
      while (pix_count < base + 3 && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      check_int("abort_after_three", pix_count - base, 3);
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      check_bit("abort_valid_low", pix_valid_o, 1'b0);
      check_bit("abort_busy_low", busy_o, 1'b0);
      repeat (3) @(posedge clk_i);
      #1;
      check_int("abort_no_done", done_count - d0, 0);
      check_int("abort_queue_drained", exp_q.size(), 0);
      check_int("abort_no_extra_pixels", pix_count - base, 3);

      // Line after the abort, negative x direction.
      pt(2,0); pt(1,0); pt(0,1); pt(-1,1); pt(-2,1);
      draw(2, 0, -2, 1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a stalled line.
      d0 = done_count;
      pix_ready_i = 1'b0;
      start_line(5, 6, 9, 9, 1'b1);
      check_int("pre_reset_x", {16'd0, pix_x_o}, 5);
      check_int("pre_reset_y", {16'd0, pix_y_o}, 6);
      repeat (2) @(posedge clk_i);
      #3 rst_i = 1'b1;
      #1;
      check_bit("async_rst_valid", pix_valid_o, 1'b0);
      check_bit("async_rst_busy", busy_o, 1'b0);
      check_bit("async_rst_last", pix_last_o, 1'b0);
      check_bit("async_rst_done", done_o, 1'b0);
      check_int("async_rst_x", {16'd0, pix_x_o}, 0);
      check_int("async_rst_y", {16'd0, pix_y_o}, 0);
      @(negedge clk_i);
      #2 rst_i = 1'b0;
      pix_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      check_bit("post_reset_idle", busy_o, 1'b0);
      check_int("post_reset_no_done", done_count - d0, 0);

      // Steep line with positive x, negative y after the reset.
      pt(-1,3); pt(0,2); pt(0,1); pt(1,0); pt(1,-1); pt(2,-2); pt(2,-3);
      draw(-1, 3, 2, -3, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gfx_line_stream.md
GFX_LINE_STREAM -- requirements
Module: gfx_line_stream

Interface
REQ-001 SHALL have parameter POINT_W, default 16, coordinate width in bits (two's complement).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports pixel0_x_i, pixel0_y_i, pixel1_x_i, pixel1_y_i  input  POINT_W  signed endpoints, sampled when a start is accepted.
REQ-005 SHALL have port start_i  input  1  request to draw a line.
REQ-006 SHALL have port abort_i  input  1  cancel the line in progress.
REQ-007 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-008 SHALL have ports pix_valid_o (output, 1) and pix_ready_i (input, 1)  pixel stream handshake.
REQ-009 SHALL have ports pix_x_o, pix_y_o  output  POINT_W  current pixel coordinate.
REQ-010 SHALL have port pix_last_o  output  1  marks the final pixel of the line; qualified by pix_valid_o.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse on normal completion.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, RUN, DONE.
REQ-013 In IDLE, start_i=1 SHALL latch the endpoints and go to SETUP; start_i outside IDLE SHALL be ignored.
REQ-014 SETUP (1 cycle) SHALL compute dx=|x1-x0| and dy=|y1-y0| at POINT_W+1 bits, steps sx,sy in {+1,-1}, x_major=(dx>=dy), dmajor/dminor accordingly, err=0, current point=p0; then go to RUN.
REQ-015 All eight octants SHALL be handled; no external delta, slope or octant inputs exist.
REQ-016 In RUN, pix_valid_o SHALL be 1 and pix_x_o/pix_y_o SHALL present the current point.
REQ-017 While pix_valid_o=1 and pix_ready_i=0, all outputs and internal state SHALL hold.
REQ-018 On a transfer (valid and ready) of a non-last pixel: major += s_major; e=err+dminor; if 2*e >= dmajor then minor += s_minor and err=e-dmajor, else err=e.
REQ-019 The error term SHALL be signed and POINT_W+3 bits wide; the comparison SHALL never overflow.
REQ-020 pix_last_o SHALL be 1 exactly when the major coordinate equals the major endpoint.
REQ-021 A transfer with pix_last_o=1 SHALL go to DONE; DONE SHALL assert done_o for one cycle and return to IDLE.
REQ-022 A line SHALL emit exactly dmajor+1 pixels; p0==p1 SHALL emit one pixel with pix_last_o=1.
REQ-023 Back-to-back transfers SHALL sustain one pixel per cycle.
REQ-024 abort_i=1 in SETUP, RUN or DONE SHALL force IDLE on the next edge, drop pix_valid_o, and suppress done_o; abort_i SHALL take priority over a simultaneous transfer.
REQ-025 Latency SHALL be start accepted at cycle N, first pix_valid_o at N+2.

Reset
REQ-026 rst_i SHALL asynchronously force IDLE, busy_o=0, pix_valid_o=0, pix_last_o=0, done_o=0, pix_x_o=0, pix_y_o=0, and clear all internal registers.
REQ-027 Reset asserted mid-line SHALL abandon the line with no done_o pulse.

Configuration
REQ-028 Macro GFX_LINE_SKIP_LAST_EN, when defined, SHALL omit the endpoint pixel so that polylines do not double-plot shared vertices.
REQ-029 With the macro defined: dmajor pixels emitted; pix_last_o on the pixel before the endpoint; p0==p1 SHALL go SETUP->DONE with zero pixels and a done_o pulse.
REQ-030 Without the macro, behaviour SHALL be exactly as in REQ-022.

Verification
REQ-031 (0,0)->(4,2) with ready=1 -> pixels (0,0),(1,1),(2,1),(3,2),(4,2); last on (4,2); done_o pulse one cycle after that pixel.
REQ-032 (3,5)->(1,0) (steep, negative x and y) -> 6 pixels ending at (1,0), y strictly decreasing, each x step at most 1.
REQ-033 (0,0)->(7,0) with pix_ready_i toggled 1,0,1,0 -> 8 pixels in order, outputs stable during each stall, no loss or duplication.
REQ-034 (-2,-2)->(-2,-2) -> single pixel (-2,-2) with last=1; with GFX_LINE_SKIP_LAST_EN defined -> zero pixels plus a done_o pulse.
REQ-035 abort_i after the 3rd transfer of (0,0)->(10,10) -> pix_valid_o=0 next cycle, busy_o=0, no done_o; a following start draws correctly.
REQ-036 rst_i asserted mid-RUN, asynchronously to the clock -> all outputs 0 immediately; start_i asserted while busy -> ignored and the current line is unaffected.
